// File: rtl/dac_pkg.sv
// Shared widths, frame length and controller state type for the DAC PWM driver.
package dac_pkg;
    localparam int DAC_W     = 8;
    localparam int FRAME_LEN = 256;

    localparam logic [DAC_W-1:0] PHASE_LAST = DAC_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dac_state_e;
endpackage

// File: rtl/dac_pwm_driver_if.sv
// Valid/ready sample stream from the upstream sample source into the DAC driver.
interface dac_pwm_driver_if;
    import dac_pkg::*;

    logic [DAC_W-1:0] sample_i;
    logic             sample_valid_i;
    logic             sample_ready_o;

    modport master (output sample_i, output sample_valid_i, input sample_ready_o);
    modport slave  (input sample_i, input sample_valid_i, output sample_ready_o);
endinterface

// File: rtl/dac_modulator.sv
// 1-bit modulator: PWM compare by default, first-order sigma-delta when
// DAC_SIGMA_DELTA_EN is defined. Output is registered and forced low when not running.
module dac_modulator
    import dac_pkg::*;
(
    input  logic             clk,
    input  logic             nRst,
    input  logic             run_i,
    input  logic [DAC_W-1:0] phase_i,
    input  logic [DAC_W-1:0] active_i,
    output logic             pwm_o
);
    logic pwm_q, pwm_d;

`ifdef DAC_SIGMA_DELTA_EN
    // Carry out of acc + active is bit 8 of the accumulator, kept in pwm_q.
    logic [DAC_W-1:0] acc_q, acc_d;
    logic [DAC_W:0]   sum;
    logic             unused_phase;

    assign unused_phase = ^phase_i;
    assign sum          = {1'b0, acc_q} + {1'b0, active_i};

    always_comb begin
        acc_d = '0;
        pwm_d = 1'b0;
        if (run_i) begin
            acc_d = sum[DAC_W-1:0];
            pwm_d = sum[DAC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            acc_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pwm_q <= pwm_d;
        end
    end
`else
    always_comb begin
        pwm_d = run_i && (phase_i < active_i);
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`endif

    assign pwm_o = pwm_q;
endmodule

// File: rtl/dac_pwm_driver.sv
// Frame controller, 1-entry sample buffer and handshake for the 1-bit DAC.
// Modulation style selected by DAC_SIGMA_DELTA_EN (see dac_modulator).
//   state | meaning
//   IDLE  | output low, phase 0, buffer keeps accepting while empty
//   RUN   | 256-cycle frames, active reloaded from buffer at phase 255
module dac_pwm_driver
    import dac_pkg::*;
(
    input  logic            clk,
    input  logic            nRst,
    dac_pwm_driver_if.slave smp,
    input  logic            enable_i,
    output logic            pwm_o,
    output logic            period_done_o,
    output logic            underrun_o
);
    dac_state_e       state_q, state_d;
    logic [DAC_W-1:0] phase_q, phase_d;
    logic [DAC_W-1:0] active_q, active_d;
    logic [DAC_W-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             period_done_q, period_done_d;
    logic             underrun_q, underrun_d;
    logic             frame_end;
    logic             xfer;
    logic             run;

    assign frame_end          = (state_q == RUN) && (phase_q == PHASE_LAST);
    assign smp.sample_ready_o = !buf_full_q || frame_end;
    assign xfer               = smp.sample_valid_i && smp.sample_ready_o;
    assign run                = (state_q == RUN) && enable_i;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        active_d      = active_q;
        buf_d         = buf_q;
        buf_full_d    = buf_full_q;
        period_done_d = 1'b0;
        underrun_d    = 1'b0;

        if (xfer) begin
            buf_d      = smp.sample_i;
            buf_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable_i && buf_full_q) begin
                    state_d    = RUN;
                    active_d   = buf_q;
                    buf_full_d = 1'b0;
                    phase_d    = '0;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + DAC_W'(1);
                    if (frame_end) begin
                        period_done_d = 1'b1;
                        // A handshake in the same cycle refills the slot just drained.
                        if (buf_full_q) begin
                            active_d   = buf_q;
                            buf_full_d = xfer;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            active_q      <= '0;
            buf_q         <= '0;
            buf_full_q    <= 1'b0;
            period_done_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            active_q      <= active_d;
            buf_q         <= buf_d;
            buf_full_q    <= buf_full_d;
            period_done_q <= period_done_d;
            underrun_q    <= underrun_d;
        end
    end

    dac_modulator u_mod (
        .clk      (clk),
        .nRst     (nRst),
        .run_i    (run),
        .phase_i  (phase_q),
        .active_i (active_q),
        .pwm_o    (pwm_o)
    );

    assign period_done_o = period_done_q;
    assign underrun_o    = underrun_q;
endmodule

// File: tb/tb_dac_pwm_driver.sv
// Self-checking bench for dac_pwm_driver: per-cycle reference model plus
// frame-level duty/streaming/underrun/abort checks and a randomized run.
module tb_dac_pwm_driver;
    logic clk;
    logic nRst;
    logic enable;
    logic pwm, pd, ur;

    dac_pwm_driver_if smp_if ();

    dac_pwm_driver dut (
        .clk           (clk),
        .nRst          (nRst),
        .smp           (smp_if),
        .enable_i      (enable),
        .pwm_o         (pwm),
        .period_done_o (pd),
        .underrun_o    (ur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit m_init = 0, m_run = 0, m_full = 0, m_take = 0;
    int m_phase = 0, m_active = 0, m_buf = 0, m_acc = 0;
    bit e_pwm = 0, e_pd = 0, e_ur = 0;

    // frame statistics taken from the DUT outputs
    int ones = 0, pd_count = 0, ur_count = 0, cyc = 0;
    int frames[$];
    int pd_cyc[$];
    logic [7:0] src_q[$];

    typedef struct {
        logic [7:0] code;
        int         exp_ones;
    } duty_vec_t;
    duty_vec_t dv[5];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of the specified behaviour; sets e_* to the outputs expected after the edge.
    task automatic model_step(input bit rn, input bit en, input bit v, input int s);
        bit rdy;
        bit take;
        rdy  = !m_full || (m_run && m_phase == 255);
        take = v && rdy;
        e_pwm = 0; e_pd = 0; e_ur = 0;
        if (!rn) begin
            m_run = 0; m_phase = 0; m_active = 0; m_buf = 0; m_full = 0; m_acc = 0;
        end else if (!m_run) begin
            if (en && m_full) begin
                m_run = 1; m_active = m_buf; m_full = 0; m_phase = 0; m_acc = 0;
            end else if (take) begin
                m_buf = s; m_full = 1;
            end
        end else if (!en) begin
            m_run = 0; m_phase = 0; m_acc = 0;
            if (take) begin m_buf = s; m_full = 1; end
        end else begin
`ifdef DAC_SIGMA_DELTA_EN
            m_acc = m_acc + m_active;
            e_pwm = (m_acc >= 256);
            m_acc = m_acc % 256;
`else
            e_pwm = (m_phase < m_active);
`endif
            if (m_phase == 255) begin
                e_pd = 1;
                if (m_full) begin
                    m_active = m_buf;
                    m_full   = take;
                    if (take) m_buf = s;
                end else begin
                    e_ur = 1;
                    if (take) begin m_buf = s; m_full = 1; end
                end
            end else if (take) begin
                m_buf = s; m_full = 1;
            end
            m_phase = (m_phase + 1) % 256;
        end
    endtask

    task automatic step(input bit rn, input bit en, input bit v, input logic [7:0] s);
        bit exp_rdy;
        nRst = rn; enable = en; smp_if.sample_valid_i = v; smp_if.sample_i = s;
        exp_rdy = !m_full || (m_run && m_phase == 255);
        #1;
        if (m_init) check("ready", int'(smp_if.sample_ready_o), int'(exp_rdy));
        m_take = v && exp_rdy && rn;
        model_step(rn, en, v, int'(s));
        if (!rn) m_init = 1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("outs{pwm,pd,ur}", int'({pwm, pd, ur}), int'({e_pwm, e_pd, e_ur}));
        if (pwm) ones++;
        if (ur) ur_count++;
        if (pd) begin
            pd_count++;
            frames.push_back(ones);
            pd_cyc.push_back(cyc);
            ones = 0;
        end
    endtask

    task automatic clear_stats();
        ones = 0; pd_count = 0; ur_count = 0;
        frames.delete(); pd_cyc.delete();
    endtask

    task automatic do_reset();
        step(0, 0, 1, 8'hAA);
        step(0, 0, 1, 8'h55);
        src_q.delete();
        clear_stats();
    endtask

    task automatic feed(input bit en);
        bit v;
        logic [7:0] s;
        v = (src_q.size() != 0);
        s = v ? src_q[0] : 8'h00;
        step(1, en, v, s);
        if (m_take) void'(src_q.pop_front());
    endtask

    task automatic run_frames(input int target, input int budget);
        int n = 0;
        while (pd_count < target && n < budget) begin
            feed(1);
            n++;
        end
        check("frames_reached", int'(pd_count >= target), 1);
    endtask

    initial begin
        int t0;
        int pd_before;
        nRst = 1'b0; enable = 1'b0;
        smp_if.sample_valid_i = 1'b0; smp_if.sample_i = 8'h00;
        @(negedge clk);

        // reset with valid held: outputs low, ready high, nothing captured
        do_reset();
        check("rst_ready", int'(smp_if.sample_ready_o), 1);
        check("rst_outs", int'({pwm, pd, ur}), 0);
        for (int i = 0; i < 300; i++) step(1, 1, 0, 8'h00);
        check("rst_no_xfer_pd", pd_count, 0);
        check("rst_no_xfer_pwm", ones, 0);

        dv[0] = '{8'd64, 64};
        dv[1] = '{8'd0, 0};
        dv[2] = '{8'd255, 255};
        dv[3] = '{8'd1, 1};
        dv[4] = '{8'd128, 128};
        for (int k = 0; k < 5; k++) begin
            do_reset();
            src_q.push_back(dv[k].code);
            run_frames(2, 700);
            check("duty_frame0", frames.size() > 0 ? frames[0] : -1, dv[k].exp_ones);
            check("duty_frame1", frames.size() > 1 ? frames[1] : -1, dv[k].exp_ones);
            check("duty_period", pd_cyc.size() > 1 ? pd_cyc[1] - pd_cyc[0] : -1, 256);
            check("duty_underruns", ur_count, 2);
        end

        // streaming: 10, 20, 30 back-to-back
        do_reset();
        src_q = '{8'd10, 8'd20, 8'd30};
        run_frames(2, 700);
        check("stream_f0", frames.size() > 0 ? frames[0] : -1, 10);
        check("stream_f1", frames.size() > 1 ? frames[1] : -1, 20);
        check("stream_no_ur", ur_count, 0);
        check("stream_drained", src_q.size(), 0);
        run_frames(3, 400);
        check("stream_f2", frames.size() > 2 ? frames[2] : -1, 30);
        check("stream_ur_after", ur_count, 1);

        // underrun: single sample repeats
        do_reset();
        src_q = '{8'd100};
        run_frames(1, 400);
        check("ur_first_start", ur_count, 1);
        run_frames(2, 400);
        check("ur_repeat_duty", frames.size() > 1 ? frames[1] : -1, 100);
        check("ur_count2", ur_count, 2);

        // abort at phase 128, then restart with buffered sample
        do_reset();
        src_q = '{8'd200, 8'd60};
        for (int i = 0; i < 400; i++) begin
            if (m_run && m_phase == 128) break;
            feed(1);
        end
        check("abort_pwm_before", int'(pwm), 1);
        pd_before = pd_count;
        step(1, 0, 0, 8'h00);
        check("abort_pwm_after", int'(pwm), 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 8'h00);
        check("abort_no_pd", pd_count, pd_before);
        clear_stats();
        step(1, 1, 0, 8'h00);
        t0 = cyc;
        run_frames(1, 400);
        check("restart_phase0", pd_cyc.size() > 0 ? pd_cyc[0] - t0 : -1, 256);
        check("restart_duty", frames.size() > 0 ? frames[0] : -1, 60);

        // reset mid-frame discards active and buffered samples
        do_reset();
        src_q = '{8'd77, 8'd88};
        for (int i = 0; i < 100; i++) feed(1);
        step(0, 1, 0, 8'h00);
        clear_stats();
        for (int i = 0; i < 300; i++) step(1, 1, 0, 8'h00);
        check("midrst_no_pd", pd_count, 0);
        check("midrst_no_ur", ur_count, 0);
        check("midrst_no_pwm", ones, 0);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step(bit'($urandom_range(0, 2999) != 0), bit'($urandom_range(0, 299) != 0),
                 bit'($urandom_range(0, 3) != 0), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
